// File: rtl/nexus_regfile_sb.sv
// Register file with two write ports, optional write-to-read bypass and a
// per-register busy scoreboard used by the hazard unit to stall operand fetch.
module nexus_regfile_sb #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 3,
   parameter bit          ZERO_R0 = 1'b0,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          rd_addr1,
   input  logic [ADDR_W-1:0]          rd_addr2,
   output logic [DATA_W-1:0]          rd_data1,
   output logic [DATA_W-1:0]          rd_data2,
   output logic                       rd_busy1,
   output logic                       rd_busy2,
   input  logic                       we_a,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic                       we_b,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_addr,
   input  logic                       flush,
   output logic                       wr_conflict,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int unsigned NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic              wa_ok;
   logic              wb_ok;
   logic              wb_store;
   logic              conflict_c;
   logic [NREGS-1:0]  wr_hit;
   logic [NREGS-1:0]  busy_nxt;

   // Writes aimed at a hardwired-zero R0 are dropped before anything else sees them.
   assign wa_ok      = we_a && !(ZERO_R0 && (wa_addr == '0));
   assign wb_ok      = we_b && !(ZERO_R0 && (wb_addr == '0));
   assign conflict_c = wa_ok && wb_ok && (wa_addr == wb_addr);
   assign wb_store   = wb_ok && !conflict_c;

   // Combinational read: R0 override first, then port A, then port B, then storage.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = regs[a];
      if (BYPASS) begin
         if (we_a && (wa_addr == a)) begin
            d = wa_data;
         end else if (we_b && (wb_addr == a)) begin
            d = wb_data;
         end
      end
      if (ZERO_R0 && (a == '0)) begin
         d = '0;
      end
      return d;
   endfunction

   // Scoreboard next state: write-clear, then flush, then issue wins.
   always_comb begin
      wr_hit   = '0;
      busy_nxt = busy_vec;
      if (wa_ok) begin
         wr_hit[wa_addr] = 1'b1;
      end
      if (wb_ok) begin
         wr_hit[wb_addr] = 1'b1;
      end
      busy_nxt = busy_nxt & ~wr_hit;
      if (flush) begin
         busy_nxt = '0;
      end
      if (issue_valid && !(ZERO_R0 && (issue_addr == '0))) begin
         busy_nxt[issue_addr] = 1'b1;
      end
   end

   always_comb begin
      rd_data1 = read_port(rd_addr1);
      rd_data2 = read_port(rd_addr2);
      rd_busy1 = busy_vec[rd_addr1] && !(BYPASS && wr_hit[rd_addr1]);
      rd_busy2 = busy_vec[rd_addr2] && !(BYPASS && wr_hit[rd_addr2]);
      if (ZERO_R0 && (rd_addr1 == '0)) begin
         rd_busy1 = 1'b0;
      end
      if (ZERO_R0 && (rd_addr2 == '0)) begin
         rd_busy2 = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
         busy_vec    <= '0;
         wr_conflict <= 1'b0;
      end else begin
         if (wa_ok) begin
            regs[wa_addr] <= wa_data;
         end
         if (wb_store) begin
            regs[wb_addr] <= wb_data;
         end
         busy_vec    <= busy_nxt;
         wr_conflict <= conflict_c;
      end
   end

endmodule

// File: tb/tb_nexus_regfile_sb.sv
// Directed bench for nexus_regfile_sb: one default instance (bypass on) and one
// with ZERO_R0=1, BYPASS=0, both driven by the same stimulus.
`timescale 1ns/1ps
module tb_nexus_regfile_sb;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk;
   logic        rst;
   logic [2:0]  rd_addr1, rd_addr2, wa_addr, wb_addr, issue_addr;
   logic [15:0] wa_data, wb_data;
   logic        we_a, we_b, issue_valid, flush;

   logic [15:0] a_d1, a_d2, z_d1, z_d2;
   logic        a_b1, a_b2, z_b1, z_b2, a_conf, z_conf;
   logic [7:0]  a_busy, z_busy;

   int total = 0;
   int bad   = 0;

   nexus_regfile_sb u_dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(a_d1), .rd_data2(a_d2), .rd_busy1(a_b1), .rd_busy2(a_b2),
      .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
      .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
      .wr_conflict(a_conf), .busy_vec(a_busy)
   );

   nexus_regfile_sb #(.ZERO_R0(1'b1), .BYPASS(1'b0)) u_dz (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(z_d1), .rd_data2(z_d2), .rd_busy1(z_b1), .rd_busy2(z_b2),
      .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
      .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
      .wr_conflict(z_conf), .busy_vec(z_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic we_a; logic [2:0] wa_addr; logic [15:0] wa_data;
      logic we_b; logic [2:0] wb_addr; logic [15:0] wb_data;
      logic iv; logic [2:0] ia; logic fl;
      logic [2:0] r1; logic [2:0] r2;
      logic [15:0] ad1; logic [15:0] ad2; logic ab1; logic ab2; logic [7:0] abusy; logic aconf;
      logic [15:0] zd1; logic [15:0] zd2; logic zb1; logic zb2; logic [7:0] zbusy; logic zconf;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      we_a = 1'b0; wa_addr = 3'd0; wa_data = 16'h0;
      we_b = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
      issue_valid = 1'b0; issue_addr = 3'd0; flush = 1'b0;
   endtask

   initial begin
      // we_a wa wa_data  we_b wb wb_data  iv ia fl  r1 r2 | default: d1 d2 b1 b2 busy conf | zero-r0/no-bypass: d1 d2 b1 b2 busy conf
      vecs[0]  = '{H,3'd3,16'hBEEF, L,3'd0,16'h0000, L,3'd0,L, 3'd3,3'd0, 16'hBEEF,16'h0000,L,L,8'h00,L, 16'h0000,16'h0000,L,L,8'h00,L};
      vecs[1]  = '{L,3'd0,16'h0000, L,3'd0,16'h0000, L,3'd0,L, 3'd3,3'd3, 16'hBEEF,16'hBEEF,L,L,8'h00,L, 16'hBEEF,16'hBEEF,L,L,8'h00,L};
      vecs[2]  = '{H,3'd5,16'h1111, H,3'd5,16'h2222, L,3'd0,L, 3'd5,3'd3, 16'h1111,16'hBEEF,L,L,8'h00,H, 16'h0000,16'hBEEF,L,L,8'h00,H};
      vecs[3]  = '{L,3'd0,16'h0000, L,3'd0,16'h0000, L,3'd0,L, 3'd5,3'd5, 16'h1111,16'h1111,L,L,8'h00,L, 16'h1111,16'h1111,L,L,8'h00,L};
      vecs[4]  = '{L,3'd0,16'h0000, L,3'd0,16'h0000, H,3'd2,L, 3'd2,3'd4, 16'h0000,16'h0000,L,L,8'h04,L, 16'h0000,16'h0000,L,L,8'h04,L};
      vecs[5]  = '{L,3'd0,16'h0000, H,3'd2,16'h00A5, H,3'd4,L, 3'd2,3'd4, 16'h00A5,16'h0000,L,L,8'h10,L, 16'h0000,16'h0000,H,L,8'h10,L};
      vecs[6]  = '{L,3'd0,16'h0000, L,3'd0,16'h0000, L,3'd0,H, 3'd2,3'd4, 16'h00A5,16'h0000,L,H,8'h00,L, 16'h00A5,16'h0000,L,H,8'h00,L};
      vecs[7]  = '{H,3'd6,16'h6666, L,3'd0,16'h0000, H,3'd6,L, 3'd6,3'd2, 16'h6666,16'h00A5,L,L,8'h40,L, 16'h0000,16'h00A5,L,L,8'h40,L};
      vecs[8]  = '{L,3'd0,16'h0000, L,3'd0,16'h0000, L,3'd0,L, 3'd6,3'd6, 16'h6666,16'h6666,H,H,8'h40,L, 16'h6666,16'h6666,H,H,8'h40,L};
      vecs[9]  = '{H,3'd0,16'hFFFF, L,3'd0,16'h0000, H,3'd0,L, 3'd0,3'd6, 16'hFFFF,16'h6666,L,H,8'h41,L, 16'h0000,16'h6666,L,H,8'h40,L};
      vecs[10] = '{L,3'd0,16'h0000, H,3'd6,16'h0707, L,3'd0,L, 3'd0,3'd6, 16'hFFFF,16'h0707,H,L,8'h01,L, 16'h0000,16'h6666,L,H,8'h00,L};
      vecs[11] = '{H,3'd0,16'h1234, H,3'd0,16'h5678, L,3'd0,L, 3'd0,3'd7, 16'h1234,16'h0000,L,L,8'h00,H, 16'h0000,16'h0000,L,L,8'h00,L};
      vecs[12] = '{H,3'd1,16'h0001, H,3'd7,16'hABCD, H,3'd7,H, 3'd7,3'd1, 16'hABCD,16'h0001,L,L,8'h80,L, 16'h0000,16'h0000,L,L,8'h80,L};
      vecs[13] = '{L,3'd0,16'h0000, L,3'd0,16'h0000, L,3'd0,L, 3'd7,3'd0, 16'hABCD,16'h1234,H,L,8'h80,L, 16'hABCD,16'h0000,H,L,8'h80,L};

      // Reset state: sweep every address while reset is held.
      idle();
      rd_addr1 = 3'd0; rd_addr2 = 3'd0;
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
         #0.4;
         chk($sformatf("rst_a_d1_%0d", a), a_d1, 16'h0000);
         chk($sformatf("rst_a_d2_%0d", a), a_d2, 16'h0000);
         chk($sformatf("rst_a_b1_%0d", a), 16'(a_b1), 16'h0);
         chk($sformatf("rst_z_d1_%0d", a), z_d1, 16'h0000);
         chk($sformatf("rst_z_b2_%0d", a), 16'(z_b2), 16'h0);
      end
      chk("rst_a_busy", 16'(a_busy), 16'h0);
      chk("rst_z_busy", 16'(z_busy), 16'h0);
      chk("rst_a_conf", 16'(a_conf), 16'h0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk) #1;

      // Table: combinational outputs mid-cycle, registered outputs just after the edge.
      for (int i = 0; i < 14; i++) begin
         we_a = vecs[i].we_a; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
         we_b = vecs[i].we_b; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         issue_valid = vecs[i].iv; issue_addr = vecs[i].ia; flush = vecs[i].fl;
         rd_addr1 = vecs[i].r1; rd_addr2 = vecs[i].r2;
         #3;
         chk($sformatf("v%0d_a_d1", i), a_d1, vecs[i].ad1);
         chk($sformatf("v%0d_a_d2", i), a_d2, vecs[i].ad2);
         chk($sformatf("v%0d_a_b1", i), 16'(a_b1), 16'(vecs[i].ab1));
         chk($sformatf("v%0d_a_b2", i), 16'(a_b2), 16'(vecs[i].ab2));
         chk($sformatf("v%0d_z_d1", i), z_d1, vecs[i].zd1);
         chk($sformatf("v%0d_z_d2", i), z_d2, vecs[i].zd2);
         chk($sformatf("v%0d_z_b1", i), 16'(z_b1), 16'(vecs[i].zb1));
         chk($sformatf("v%0d_z_b2", i), 16'(z_b2), 16'(vecs[i].zb2));
         @(posedge clk) #1;
         chk($sformatf("v%0d_a_busy", i), 16'(a_busy), 16'(vecs[i].abusy));
         chk($sformatf("v%0d_a_conf", i), 16'(a_conf), 16'(vecs[i].aconf));
         chk($sformatf("v%0d_z_busy", i), 16'(z_busy), 16'(vecs[i].zbusy));
         chk($sformatf("v%0d_z_conf", i), 16'(z_conf), 16'(vecs[i].zconf));
      end

      // Load R1..R7 (issuing each), final load collides with port B.
      for (int i = 1; i < 8; i++) begin
         idle();
         we_a = 1'b1; wa_addr = 3'(i); wa_data = 16'(i) * 16'h1111;
         issue_valid = 1'b1; issue_addr = 3'(i);
         if (i == 7) begin
            we_b = 1'b1; wb_addr = 3'd7; wb_data = 16'hDEAD;
         end
         @(posedge clk) #1;
      end
      idle();
      rd_addr1 = 3'd7; rd_addr2 = 3'd4;
      #1;
      chk("load_a_r7", a_d1, 16'h7777);
      chk("load_z_r4", z_d2, 16'h4444);
      chk("load_a_busy", 16'(a_busy), 16'h00FE);
      chk("load_z_busy", 16'(z_busy), 16'h00FE);
      chk("load_a_conf", 16'(a_conf), 16'h1);
      chk("load_z_conf", 16'(z_conf), 16'h1);

      // Mid-cycle reset pulse clears everything before the next edge.
      rst = 1'b0;
      #0.5;
      for (int a = 0; a < 8; a++) begin
         rd_addr1 = 3'(a); rd_addr2 = 3'(a);
         #0.4;
         chk($sformatf("pulse_a_d1_%0d", a), a_d1, 16'h0000);
         chk($sformatf("pulse_z_d2_%0d", a), z_d2, 16'h0000);
         chk($sformatf("pulse_a_b1_%0d", a), 16'(a_b1), 16'h0);
      end
      chk("pulse_a_busy", 16'(a_busy), 16'h0);
      chk("pulse_z_busy", 16'(z_busy), 16'h0);
      chk("pulse_a_conf", 16'(a_conf), 16'h0);

      // Activity presented across an edge while reset is low is ignored.
      we_a = 1'b1; wa_addr = 3'd3; wa_data = 16'h3C3C;
      issue_valid = 1'b1; issue_addr = 3'd3;
      @(posedge clk) #1;
      idle();
      rd_addr1 = 3'd3; rd_addr2 = 3'd3;
      #2 rst = 1'b1;
      #1;
      chk("post_a_r3", a_d1, 16'h0000);
      chk("post_z_r3", z_d2, 16'h0000);
      chk("post_a_busy", 16'(a_busy), 16'h0);
      chk("post_z_busy", 16'(z_busy), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
